// File: rtl/input_m_if.sv
// Bundles the button inputs, the counter timestamp and the edit outputs exchanged
// between the user-input stage and its surroundings.
interface input_m_if;
  logic        btn_mode;
  logic        btn_hour;
  logic        btn_min;
  logic        btn_alarm;
  logic [16:0] counter_state;
  logic        set_flag;
  logic [16:0] set_time;
  logic        alarm_flag;
  logic [16:0] alarm_time;
  logic [1:0]  mode;

  modport master (
    output btn_mode, btn_hour, btn_min, btn_alarm, counter_state,
    input  set_flag, set_time, alarm_flag, alarm_time, mode
  );

  modport slave (
    input  btn_mode, btn_hour, btn_min, btn_alarm, counter_state,
    output set_flag, set_time, alarm_flag, alarm_time, mode
  );
endinterface

// File: rtl/input_m.sv
// Push-button front end for the clock: synchronises and debounces four buttons and
// runs the RUN / SET_TIME / SET_ALARM edit FSM over seconds-of-day timestamps.
module input_m #(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned COUNTER_MAX     = 86399,
  parameter int unsigned HOUR_TICK       = 3600,
  parameter int unsigned MIN_TICK        = 60
) (
  input  logic       clock,
  input  logic       reset_n,
  input_m_if.slave   bus
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [17:0] DAY18     = 18'(COUNTER_MAX + 1);
  localparam logic [17:0] MAX18     = 18'(COUNTER_MAX);
  localparam logic [17:0] HOUR18    = 18'(HOUR_TICK);
  localparam logic [16:0] HOUR17    = 17'(HOUR_TICK);
  localparam logic [16:0] MIN17     = 17'(MIN_TICK);
  localparam logic [16:0] LAST_MIN17 = 17'(HOUR_TICK - MIN_TICK);

  localparam int BTN_MODE  = 0;
  localparam int BTN_HOUR  = 1;
  localparam int BTN_MIN   = 2;
  localparam int BTN_ALARM = 3;

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    SET_TIME  = 2'd1,
    SET_ALARM = 2'd2
  } state_e;

  logic [3:0]            btn_raw;
  logic [3:0]            sync1_q;
  logic [3:0]            sync2_q;
  logic [3:0]            level_q;
  logic [3:0]            level_d;
  logic [3:0]            level_prev_q;
  logic [3:0][CNT_W-1:0] cnt_q;
  logic [3:0][CNT_W-1:0] cnt_d;
  logic [3:0]            press;

  state_e      state_q, state_d;
  logic        set_flag_q, set_flag_d;
  logic [16:0] set_time_q, set_time_d;
  logic        alarm_flag_q, alarm_flag_d;
  logic [16:0] alarm_time_q, alarm_time_d;
  logic        alarm_saved_q, alarm_saved_d;
  logic [16:0] edit_base;
  logic [16:0] edit_next;

  assign btn_raw = {bus.btn_alarm, bus.btn_min, bus.btn_hour, bus.btn_mode};

  function automatic logic [16:0] hour_step(input logic [16:0] t);
    logic [17:0] sum;
    sum = {1'b0, t} + HOUR18;
    if (sum > MAX18) begin
      sum = sum - DAY18;
    end
    return sum[16:0];
  endfunction

  // Minutes wrap 59 -> 0 inside the same hour rather than carrying.
  function automatic logic [16:0] min_step(input logic [16:0] t);
    logic [16:0] res;
    if ((t % HOUR17) >= LAST_MIN17) begin
      res = t - LAST_MIN17;
    end else begin
      res = t + MIN17;
    end
    return res;
  endfunction

  // A level is accepted only after the synchronised input disagrees for a full window.
  always_comb begin
    level_d = level_q;
    cnt_d   = cnt_q;
    for (int i = 0; i < 4; i++) begin
      if (sync2_q[i] != level_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          level_d[i] = sync2_q[i];
          cnt_d[i]   = '0;
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end else begin
        cnt_d[i] = '0;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q      <= '0;
      sync2_q      <= '0;
      level_q      <= '0;
      level_prev_q <= '0;
      cnt_q        <= '0;
    end else begin
      sync1_q      <= btn_raw;
      sync2_q      <= sync1_q;
      level_q      <= level_d;
      level_prev_q <= level_q;
      cnt_q        <= cnt_d;
    end
  end

  assign press = level_q & ~level_prev_q;

  always_comb begin
    edit_base = (state_q == SET_ALARM) ? alarm_time_q : set_time_q;
    edit_next = edit_base;
    if (press[BTN_HOUR]) begin
      edit_next = hour_step(edit_next);
    end
    if (press[BTN_MIN]) begin
      edit_next = min_step(edit_next);
    end
  end

  // Mode presses take priority; any hour/min pulse in the same cycle is dropped.
  always_comb begin
    state_d       = state_q;
    set_flag_d    = set_flag_q;
    set_time_d    = set_time_q;
    alarm_flag_d  = alarm_flag_q;
    alarm_time_d  = alarm_time_q;
    alarm_saved_d = alarm_saved_q;
    case (state_q)
      RUN: begin
        if (press[BTN_MODE]) begin
          state_d    = SET_TIME;
          set_flag_d = 1'b1;
          set_time_d = bus.counter_state - (bus.counter_state % MIN17);
        end else if (press[BTN_ALARM]) begin
          alarm_flag_d = ~alarm_flag_q;
        end
      end
      SET_TIME: begin
        if (press[BTN_MODE]) begin
          state_d       = SET_ALARM;
          set_flag_d    = 1'b0;
          alarm_saved_d = alarm_flag_q;
          alarm_flag_d  = 1'b0;
        end else begin
          set_time_d = edit_next;
        end
      end
      SET_ALARM: begin
        if (press[BTN_MODE]) begin
          state_d      = RUN;
          alarm_flag_d = alarm_saved_q;
        end else begin
          alarm_time_d = edit_next;
        end
      end
      default: begin
        state_d    = RUN;
        set_flag_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= RUN;
      set_flag_q    <= 1'b0;
      set_time_q    <= '0;
      alarm_flag_q  <= 1'b0;
      alarm_time_q  <= '0;
      alarm_saved_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      set_flag_q    <= set_flag_d;
      set_time_q    <= set_time_d;
      alarm_flag_q  <= alarm_flag_d;
      alarm_time_q  <= alarm_time_d;
      alarm_saved_q <= alarm_saved_d;
    end
  end

  assign bus.mode       = state_q;
  assign bus.set_flag   = set_flag_q;
  assign bus.set_time   = set_time_q;
  assign bus.alarm_flag = alarm_flag_q;
  assign bus.alarm_time = alarm_time_q;

endmodule

// File: tb/tb_input_m.sv
// Directed bench for input_m: expected output snapshots are queued as each button
// action is driven and compared once the debounced action has settled.
module tb_input_m;

  localparam int DB = 4;

  localparam logic [3:0] B_MODE  = 4'b0001;
  localparam logic [3:0] B_HOUR  = 4'b0010;
  localparam logic [3:0] B_MIN   = 4'b0100;
  localparam logic [3:0] B_ALARM = 4'b1000;

  typedef struct packed {
    logic [1:0]  mode;
    logic        set_flag;
    logic [16:0] set_time;
    logic        alarm_flag;
    logic [16:0] alarm_time;
  } snap_t;

  logic clock;
  logic reset_n;

  input_m_if bus ();

  input_m #(.DEBOUNCE_CYCLES(DB)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  snap_t       sb_q [$];
  int          checks;
  int          failures;
  logic [1:0]  m_mode;
  logic        m_set_flag;
  logic [16:0] m_set_time;
  logic        m_alarm_flag;
  logic [16:0] m_alarm_time;

  task automatic pushExpected();
    snap_t s;
    s.mode       = m_mode;
    s.set_flag   = m_set_flag;
    s.set_time   = m_set_time;
    s.alarm_flag = m_alarm_flag;
    s.alarm_time = m_alarm_time;
    sb_q.push_back(s);
  endtask

  task automatic checkOutput(input string tag);
    snap_t exp_s;
    snap_t obs_s;
    obs_s = {bus.mode, bus.set_flag, bus.set_time, bus.alarm_flag, bus.alarm_time};
    checks++;
    if (sb_q.size() == 0) begin
      failures++;
      $error("[TB] FAIL %s: scoreboard empty, observed mode=%0d", tag, obs_s.mode);
    end else begin
      exp_s = sb_q.pop_front();
      assert (obs_s === exp_s) else begin
        failures++;
        $error("[TB] FAIL %s: observed mode=%0d sf=%0b st=%0d af=%0b at=%0d expected mode=%0d sf=%0b st=%0d af=%0b at=%0d",
               tag, obs_s.mode, obs_s.set_flag, obs_s.set_time, obs_s.alarm_flag, obs_s.alarm_time,
               exp_s.mode, exp_s.set_flag, exp_s.set_time, exp_s.alarm_flag, exp_s.alarm_time);
      end
    end
  endtask

  task automatic driveButtons(input logic [3:0] mask);
    bus.btn_mode  = mask[0];
    bus.btn_hour  = mask[1];
    bus.btn_min   = mask[2];
    bus.btn_alarm = mask[3];
  endtask

  // One clean press: expected state is queued as the buttons go down.
  task automatic applyStimulus(input logic [3:0] mask);
    @(negedge clock);
    pushExpected();
    driveButtons(mask);
    repeat (DB + 5) @(negedge clock);
    driveButtons(4'b0000);
    repeat (DB + 6) @(negedge clock);
  endtask

  initial begin
    checks       = 0;
    failures     = 0;
    m_mode       = 2'd0;
    m_set_flag   = 1'b0;
    m_set_time   = 17'd0;
    m_alarm_flag = 1'b0;
    m_alarm_time = 17'd0;
    reset_n      = 1'b0;
    driveButtons(4'b0000);
    bus.counter_state = 17'd34953;

    #1;
    pushExpected();
    checkOutput("reset_state");
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    repeat (2) @(negedge clock);
    pushExpected();
    checkOutput("after_reset_idle");

    // Bouncing mode button must never be accepted.
    for (int k = 0; k < 10; k++) begin
      bus.btn_mode = (k % 2 == 0);
      pushExpected();
      repeat (2) @(negedge clock);
      checkOutput("bounce_no_change");
    end
    bus.btn_mode = 1'b1;
    repeat (6) @(negedge clock);
    pushExpected();
    checkOutput("stable_before_latency");
    @(negedge clock);
    m_mode     = 2'd1;
    m_set_flag = 1'b1;
    m_set_time = 17'd34920;
    pushExpected();
    checkOutput("enter_set_time_latency");
    repeat (100) @(negedge clock);
    pushExpected();
    checkOutput("held_no_repeat");
    bus.btn_mode = 1'b0;
    repeat (DB + 6) @(negedge clock);

    for (int k = 1; k <= 3; k++) begin
      m_set_time = 17'(34920 + k * 3600);
      applyStimulus(B_HOUR);
      checkOutput("hour_press");
    end

    applyStimulus(B_ALARM);
    checkOutput("alarm_ignored_in_set_time");

    m_mode = 2'd2; m_set_flag = 1'b0;
    applyStimulus(B_MODE);
    checkOutput("to_set_alarm");
    m_mode = 2'd0;
    applyStimulus(B_MODE);
    checkOutput("to_run");
    applyStimulus(B_HOUR | B_MIN);
    checkOutput("edit_ignored_in_run");

    bus.counter_state = 17'd37165;
    m_mode = 2'd1; m_set_flag = 1'b1; m_set_time = 17'd37140;
    applyStimulus(B_MODE);
    checkOutput("enter_set_time_1019");
    for (int k = 1; k <= 41; k++) begin
      m_set_time = 17'(36000 + ((19 + k) % 60) * 60);
      applyStimulus(B_MIN);
      checkOutput("minute_wrap_step");
    end

    m_mode = 2'd2; m_set_flag = 1'b0;
    applyStimulus(B_MODE);
    checkOutput("cycle_to_alarm");
    m_mode = 2'd0;
    applyStimulus(B_MODE);
    checkOutput("cycle_to_run");
    bus.counter_state = 17'd86359;
    m_mode = 2'd1; m_set_flag = 1'b1; m_set_time = 17'd86340;
    applyStimulus(B_MODE);
    checkOutput("enter_set_time_2359");
    m_set_time = 17'd3540;
    applyStimulus(B_HOUR);
    checkOutput("hour_wrap_day");
    m_set_time = 17'd0;
    applyStimulus(B_MIN);
    checkOutput("minute_wrap_to_zero");

    m_mode = 2'd2; m_set_flag = 1'b0;
    applyStimulus(B_MODE);
    checkOutput("to_alarm_again");
    m_mode = 2'd0;
    applyStimulus(B_MODE);
    checkOutput("to_run_again");
    m_alarm_flag = 1'b1;
    applyStimulus(B_ALARM);
    checkOutput("alarm_toggle_on");
    m_mode = 2'd1; m_set_flag = 1'b1; m_set_time = 17'd86340;
    applyStimulus(B_MODE);
    checkOutput("set_time_alarm_kept");
    m_mode = 2'd2; m_set_flag = 1'b0; m_alarm_flag = 1'b0;
    applyStimulus(B_MODE);
    checkOutput("alarm_suppressed_in_edit");
    for (int k = 1; k <= 14; k++) begin
      m_alarm_time = 17'(k * 3600);
      applyStimulus(B_HOUR);
      checkOutput("alarm_hour_step");
    end
    for (int k = 1; k <= 8; k++) begin
      m_alarm_time = 17'(50400 + k * 60);
      applyStimulus(B_MIN);
      checkOutput("alarm_min_step");
    end
    m_mode = 2'd0; m_alarm_flag = 1'b1;
    applyStimulus(B_MODE);
    checkOutput("alarm_restored_on_run");
    m_alarm_flag = 1'b0;
    applyStimulus(B_ALARM);
    checkOutput("alarm_toggle_off");

    bus.counter_state = 17'd0;
    m_mode = 2'd1; m_set_flag = 1'b1; m_set_time = 17'd0;
    applyStimulus(B_MODE);
    checkOutput("enter_set_time_zero");
    m_set_time = 17'd3660;
    applyStimulus(B_HOUR | B_MIN);
    checkOutput("hour_and_min_same_cycle");
    m_mode = 2'd2; m_set_flag = 1'b0;
    applyStimulus(B_MODE | B_HOUR);
    checkOutput("mode_wins_over_hour");
    m_mode = 2'd0;
    applyStimulus(B_MODE);
    checkOutput("back_to_run");

    bus.counter_state = 17'd7213;
    m_mode = 2'd1; m_set_flag = 1'b1; m_set_time = 17'd7200;
    applyStimulus(B_MODE);
    checkOutput("enter_set_time_7200");
    #2;
    reset_n = 1'b0;
    #1;
    m_mode = 2'd0; m_set_flag = 1'b0; m_set_time = 17'd0;
    m_alarm_flag = 1'b0; m_alarm_time = 17'd0;
    pushExpected();
    checkOutput("async_reset_mid_edit");

    $display("[TB] directed sequence complete");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
